// File: rtl/cpu_axi_pkg.sv
// ============================================================================
// cpu_axi_pkg : AXI encodings and FSM state type shared by the CPU-side AXI
//               bridges.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_axi_pkg;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } inst_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_axi_responder.sv
// ============================================================================
// inst_axi_responder : one-entry instruction buffer refilled by single-beat
//                      AXI reads. Optional macro INST_AXI_ERR_EN adds the
//                      inst_bus_err pulse output.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module inst_axi_responder
  import cpu_axi_pkg::*;
#(
  parameter int          ID_W  = 4,
  parameter int unsigned AR_ID = 0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inst_sram_en,
  input  logic [31:0]     inst_sram_addr,
  output logic [31:0]     inst_sram_rdata,
  output logic            inst_stall,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready
`ifdef INST_AXI_ERR_EN
  ,
  output logic            inst_bus_err
`endif
);

  inst_resp_state_t state_q, state_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        hit;

  assign hit             = buf_valid_q && (buf_addr_q == inst_sram_addr);
  assign inst_stall      = inst_sram_en && !hit;
  assign inst_sram_rdata = buf_data_q;

  assign arid    = ID_W'(AR_ID);
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    araddr_d    = araddr_q;
    req_addr_d  = req_addr_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    case (state_q)
      IDLE: begin
        if (inst_sram_en && !hit) begin
          req_addr_d = inst_sram_addr;
          araddr_d   = {inst_sram_addr[31:2], 2'b00};
          arvalid_d  = 1'b1;
          state_d    = AR;
        end
      end
      AR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        // Tag is the address captured at issue, so a redirect during the
        // read leaves a stale-but-correct entry that simply misses later.
        if (rready_q && rvalid && rlast) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = req_addr_q;
          buf_data_d  = rdata;
          rready_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      araddr_q    <= 32'd0;
      req_addr_q  <= 32'd0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= 32'd0;
      buf_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      araddr_q    <= araddr_d;
      req_addr_q  <= req_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end

`ifdef INST_AXI_ERR_EN
  logic bus_err_q, bus_err_d;

  assign bus_err_d    = rready_q && rvalid && (rresp != AXI_RESP_OKAY);
  assign inst_bus_err = bus_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^rid;
`else
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp};
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_axi_responder.sv
// ============================================================================
// tb_inst_axi_responder : directed vector bench for inst_axi_responder.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_inst_axi_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        inst_stall;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
`ifdef INST_AXI_ERR_EN
  logic        inst_bus_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_axi_responder #(.ID_W(4), .AR_ID(0)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .inst_stall      (inst_stall),
    .arid            (arid),
    .araddr          (araddr),
    .arlen           (arlen),
    .arsize          (arsize),
    .arburst         (arburst),
    .arvalid         (arvalid),
    .arready         (arready),
    .rid             (rid),
    .rdata           (rdata),
    .rresp           (rresp),
    .rlast           (rlast),
    .rvalid          (rvalid),
    .rready          (rready)
`ifdef INST_AXI_ERR_EN
    ,
    .inst_bus_err    (inst_bus_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one fetch and plays a single-outstanding AXI slave until the
  // stall drops. Optionally redirects the fetch address on the first R cycle.
  task automatic run_fetch(
    input  logic [31:0] addr,
    input  int          ard,
    input  int          rd,
    input  logic [31:0] d1,
    input  logic [1:0]  resp,
    input  logic        redir,
    input  logic [31:0] raddr,
    input  logic [31:0] d2,
    output int          stalls,
    output int          n_ar,
    output logic [31:0] last_ar,
    output logic        stable,
    output logic        consts_ok,
    output int          errs,
    output logic        done
  );
    int   arw, rw;
    logic ar_seen, redirected;
    logic [31:0] ar_first;
    stalls = 0; n_ar = 0; last_ar = '0; stable = 1'b1; consts_ok = 1'b1;
    errs = 0; done = 1'b0; arw = 0; rw = 0; ar_seen = 1'b0; redirected = 1'b0;
    ar_first = '0;
    inst_sram_en   = 1'b1;
    inst_sram_addr = addr;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
      #1;
`ifdef INST_AXI_ERR_EN
      errs += int'(inst_bus_err);
`endif
      if (!inst_stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (arvalid) begin
          if (!ar_seen) begin
            ar_first = araddr;
            ar_seen  = 1'b1;
          end else if (araddr !== ar_first) begin
            stable = 1'b0;
          end
          if (arlen !== 8'd0 || arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'd0)
            consts_ok = 1'b0;
          if (arw == ard) begin
            arready = 1'b1;
            n_ar++;
            last_ar = araddr;
          end else begin
            arw++;
          end
        end
        if (rready) begin
          if (redir && !redirected) begin
            inst_sram_addr = raddr;
            redirected     = 1'b1;
          end
          if (rw == rd) begin
            rvalid = 1'b1;
            rlast  = 1'b1;
            rresp  = resp;
            rdata  = (n_ar <= 1) ? d1 : d2;
            arw = 0; rw = 0; ar_seen = 1'b0;
          end else begin
            rw++;
          end
        end
        @(negedge clk);
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          ard;
    int          rd;
    logic [31:0] data;
    logic [1:0]  resp;
    int          exp_stalls;
    logic [31:0] exp_araddr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          stalls, n_ar, errs;
    logic [31:0] last_ar;
    logic        stable, consts_ok, done;

    vecs[0] = '{32'hbfc00000, 0, 0, 32'h3c080001, 2'b00, 3, 32'hbfc00000};
    vecs[1] = '{32'hbfc00010, 4, 2, 32'h24090002, 2'b00, 9, 32'hbfc00010};
    vecs[2] = '{32'hbfc00023, 1, 0, 32'h8d2a0000, 2'b00, 4, 32'hbfc00020};
    vecs[3] = '{32'h00000000, 0, 3, 32'hffffffff, 2'b00, 6, 32'h00000000};
    vecs[4] = '{32'hfffffffc, 2, 1, 32'h12345678, 2'b10, 6, 32'hfffffffc};

    resetn = 1'b0; inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00000;
    arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_arvalid", {31'd0, arvalid}, 32'd0);
    check("reset_rready", {31'd0, rready}, 32'd0);
    check("reset_araddr", araddr, 32'd0);
    check("reset_rdata", inst_sram_rdata, 32'd0);
    check("reset_stall", {31'd0, inst_stall}, 32'd1);
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_fetch(vecs[i].addr, vecs[i].ard, vecs[i].rd, vecs[i].data, vecs[i].resp,
                1'b0, 32'd0, 32'd0, stalls, n_ar, last_ar, stable, consts_ok, errs, done);
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_stalls", i), stalls, vecs[i].exp_stalls);
      check($sformatf("v%0d_n_ar", i), n_ar, 32'd1);
      check($sformatf("v%0d_araddr", i), last_ar, vecs[i].exp_araddr);
      check($sformatf("v%0d_ar_stable", i), {31'd0, stable}, 32'd1);
      check($sformatf("v%0d_ar_consts", i), {31'd0, consts_ok}, 32'd1);
      check($sformatf("v%0d_rdata", i), inst_sram_rdata, vecs[i].data);
`ifdef INST_AXI_ERR_EN
      check($sformatf("v%0d_bus_err_pulses", i), errs, (vecs[i].resp != 2'b00) ? 32'd1 : 32'd0);
`endif
      // Holding the same address must keep hitting with no new read.
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); #1;
        check($sformatf("v%0d_hold_stall", i), {31'd0, inst_stall}, 32'd0);
        check($sformatf("v%0d_hold_arvalid", i), {31'd0, arvalid}, 32'd0);
        check($sformatf("v%0d_hold_rdata", i), inst_sram_rdata, vecs[i].data);
`ifdef INST_AXI_ERR_EN
        check($sformatf("v%0d_bus_err_clear", i), {31'd0, inst_bus_err}, 32'd0);
`endif
      end
      @(negedge clk);
    end

    // Disabled fetch on a missing address: no stall, no read.
    inst_sram_en = 1'b0; inst_sram_addr = 32'h80000000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("en0_stall", {31'd0, inst_stall}, 32'd0);
      check("en0_arvalid", {31'd0, arvalid}, 32'd0);
      @(negedge clk);
    end

    // Redirect while the first read is in R.
    run_fetch(32'hbfc00004, 0, 0, 32'h11111111, 2'b00, 1'b1, 32'hbfc00100, 32'h22222222,
              stalls, n_ar, last_ar, stable, consts_ok, errs, done);
    check("redir_done", {31'd0, done}, 32'd1);
    check("redir_n_ar", n_ar, 32'd2);
    check("redir_araddr", last_ar, 32'hbfc00100);
    check("redir_stalls", stalls, 32'd6);
    check("redir_rdata", inst_sram_rdata, 32'h22222222);
    @(negedge clk);
    inst_sram_addr = 32'hbfc00004;
    #1;
    check("redir_old_tag_miss", {31'd0, inst_stall}, 32'd1);
    @(negedge clk);
    inst_sram_en = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset while the AR is pending.
    inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00040; arready = 1'b0;
    @(negedge clk); #1;
    check("rst_ar_arvalid_before", {31'd0, arvalid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_ar_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_ar_araddr", araddr, 32'd0);
    inst_sram_addr = 32'h22222222;
    #1;
    check("rst_ar_buf_invalid", {31'd0, inst_stall}, 32'd1);
    check("rst_ar_rdata", inst_sram_rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_fetch(32'hbfc00100, 0, 0, 32'h33333333, 2'b00, 1'b0, 32'd0, 32'd0,
              stalls, n_ar, last_ar, stable, consts_ok, errs, done);
    check("refetch_done", {31'd0, done}, 32'd1);
    check("refetch_stalls", stalls, 32'd3);
    check("refetch_n_ar", n_ar, 32'd1);
    check("refetch_rdata", inst_sram_rdata, 32'h33333333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_axi_responder.md
# inst_axi_responder

Responder side of the instruction fetch interface. Accepts the fetch stage's `inst_sram_en`/`inst_sram_addr` request, fetches the word over an AXI read channel, and returns `inst_sram_rdata` with `inst_stall` held until the data for the presented address is ready. It sits between the fetch stage and the AXI crossbar, replacing a direct SRAM on the instruction side of the SoC.

## Interface
- `ID_W`, 4, width of AXI ID fields.
- `AR_ID`, 0, constant ID driven on `arid`.
- `clk` input 1 — system clock, all logic on posedge.
- `resetn` input 1 — asynchronous, active-low reset.
- `inst_sram_en` input 1 — fetch request valid.
- `inst_sram_addr` input 32 — word address requested; held stable by fetch while `inst_stall`=1.
- `inst_sram_rdata` output 32 — instruction word for the current address; valid when `inst_sram_en`=1 and `inst_stall`=0.
- `inst_stall` output 1 — data for the presented address not yet available.
- `arid` output ID_W; `araddr` output 32; `arlen` output 8; `arsize` output 3; `arburst` output 2; `arvalid` output 1; `arready` input 1.
- `rid` input ID_W; `rdata` input 32; `rresp` input 2; `rlast` input 1; `rvalid` input 1; `rready` output 1.
- `inst_bus_err` output 1 — present only with `INST_AXI_ERR_EN` (see Configuration).

## Operation
- Result buffer: `buf_valid`, `buf_addr[31:0]`, `buf_data[31:0]`. Hit = `buf_valid` & `buf_addr==inst_sram_addr`.
- `inst_stall` = `inst_sram_en` & ~hit (combinational). `inst_sram_rdata` = `buf_data`.
- FSM states: IDLE, AR, R.
  - IDLE: `inst_sram_en` & ~hit → latch `req_addr`=`inst_sram_addr`, `araddr`=`{inst_sram_addr[31:2],2'b00}`, `arvalid`=1, go to AR. Otherwise stay.
  - AR: `arvalid`=1 until `arready`; on handshake `arvalid`=0, go to R. `araddr` is stable while `arvalid`=1.
  - R: `rready`=1. On `rvalid` & `rlast`, write `buf_data`=`rdata`, `buf_addr`=`req_addr`, `buf_valid`=1, then go to IDLE. `rid` is not checked (single outstanding read).
- Constants: `arlen`=0, `arsize`=3'b010, `arburst`=2'b01, `arid`=AR_ID.
- Exactly one outstanding read; transactions are never aborted.
- Address change mid-transaction (redirect/flush at fetch): the transaction completes and the buffer is written with the old address. The tag then misses, so IDLE issues a new read. No flush port is needed.
- `inst_sram_en`=0: no new requests. An in-flight transaction still completes.
- Reset (async, any state): state=IDLE, `arvalid`=0, `araddr`=0, `rready`=0, `buf_valid`=0, `buf_addr`=0, `buf_data`=0. An AXI read in flight at reset is abandoned; the interconnect is reset together with the block.

## Timing
- Miss, zero-wait slave: cycle 0 request seen in IDLE; cycle 1 `arvalid`=1, `arready`=1; cycle 2 `rvalid`; cycle 3 `inst_stall`=0 and `inst_sram_rdata` valid. Minimum miss penalty is 3 stall cycles.
- Each `arready` or `rvalid` wait cycle adds 1 stall cycle.
- Hit: `inst_stall`=0 in the same cycle; data appears combinationally from the buffer.
- The buffer write and the IDLE re-evaluation against the new address happen in the same cycle. A miss in that cycle starts a new AR on the next edge.

## Configuration
- `INST_AXI_ERR_EN` defined: `inst_bus_err` is a one-cycle pulse, registered, on the cycle after an R beat with `rresp`≠2'b00. The word is still written into the buffer.
- `INST_AXI_ERR_EN` undefined: the `inst_bus_err` port is absent and `rresp` is ignored.

## Structure
- Shared package `cpu_axi_pkg` holds:
  - `AXI_SIZE_WORD`=3'b010
  - `AXI_BURST_INCR`=2'b01
  - `AXI_RESP_OKAY`=2'b00
  - the `inst_resp_state_t` enum {IDLE, AR, R}
- Single module; no sub-module is warranted. FSM and buffer share one always block set.

## Test plan
- Reset then `inst_sram_en`=1, addr 0xbfc00000; slave returns 0x3c080001 with zero waits → `inst_stall` high exactly 3 cycles; `araddr`=0xbfc00000, `arlen`=0; `inst_sram_rdata`=0x3c080001 on cycle 3.
- Same address held after completion → no new `arvalid`; `inst_stall`=0 every cycle.
- `arready` delayed 4 cycles, `rvalid` delayed 2 → `araddr` stable throughout; stall lasts 3+4+2 cycles.
- Address changes 0xbfc00004→0xbfc00100 while in R → first read completes; second AR issued with 0xbfc00100; `inst_stall` drops only after the 0xbfc00100 data arrives.
- `resetn` asserted in AR state → `arvalid`=0 and `buf_valid`=0 immediately (asynchronous); after release the next request re-fetches.
- With `INST_AXI_ERR_EN`, `rresp`=2'b10 → `inst_bus_err` pulses 1 cycle; without the macro, identical data behaviour and no error port.
